// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding and helpers for the LSB-first serial comparator
package cmp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
  localparam int SLICE_MAX = 32;
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic slice_lt(input logic [SLICE_MAX-1:0] a, input logic [SLICE_MAX-1:0] b);
    return a < b;
  endfunction
endpackage

// File: rtl/lsb_serial_cmp_slice.sv
// slice_cmp: one SLICE-wide compare, sign bit flipped on the top slice of a signed compare
module slice_cmp
  import cmp_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             top,
  input  logic             Signed,
  output logic             lt,
  output logic             ne
);
  logic [SLICE-1:0] w_flip;
  assign w_flip = (top && Signed) ? SLICE'(1) << (SLICE - 1) : '0;
  assign lt = slice_lt(SLICE_MAX'(a ^ w_flip), SLICE_MAX'(b ^ w_flip));
  assign ne = a != b;
endmodule

// File: rtl/lsb_serial_cmp.sv
// lsb_serial_cmp: multi-cycle LSB-first magnitude comparator with valid/ready on both sides
module lsb_serial_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Less,
  output logic             Equal
);
  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IW = idx_w(NSLICE);
  cmp_state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [IW-1:0] r_idx;
  logic r_signed, r_lt, r_eq;
  logic w_last, w_accept, w_lt, w_ne;
  assign w_last = r_idx == IW'(NSLICE - 1);
  assign w_accept = r_state == IDLE && in_valid && !flush;
  slice_cmp #(.SLICE(SLICE)) u_slice (
    .a(r_a[r_idx*SLICE +: SLICE]),
    .b(r_b[r_idx*SLICE +: SLICE]),
    .top(w_last),
    .Signed(r_signed),
    .lt(w_lt),
    .ne(w_ne)
  );
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = flush ? IDLE :
             r_state == IDLE ? (in_valid ? RUN : IDLE) :
             r_state == RUN ? (w_last ? DONE : RUN) :
             (out_ready ? IDLE : DONE);
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    Less = r_state == DONE && r_lt;
    Equal = r_state == DONE && r_eq;
  end
  // Later slices are more significant, so any differing slice overwrites the verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_signed <= 1'b0;
      r_idx <= '0;
      r_lt <= 1'b0;
      r_eq <= 1'b0;
    end else if (w_accept) begin
      r_a <= A;
      r_b <= B;
      r_signed <= Signed;
      r_idx <= '0;
      r_lt <= 1'b0;
      r_eq <= 1'b1;
    end else if (r_state == RUN) begin
      if (w_ne) begin
        r_lt <= w_lt;
        r_eq <= 1'b0;
      end
      if (!w_last) r_idx <= r_idx + IW'(1);
    end
  end
endmodule
